// File: rtl/cascade_controller_pkg.sv
// Shared definitions for the cascade controller: FSM state encoding and the
// layout of one stage-table entry in the cascade ROM.
package cascade_controller_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTblWait = 3'd1,
        StTblRead = 3'd2,
        StSeStart = 3'd3,
        StSeWait  = 3'd4,
        StResult  = 3'd5
    } state_e;

    // Words per stage entry; word 3 is reserved and never fetched.
    localparam int unsigned StageStride = 4;

    // Word offsets inside one stage entry
    localparam logic [1:0] WordBase   = 2'd0;
    localparam logic [1:0] WordThresh = 2'd1;
    localparam logic [1:0] WordCount  = 2'd2;

endpackage

// File: rtl/cascade_controller.sv
// Cascade controller: walks the stage table of one detection window, fetching
// each stage entry from the cascade ROM (one wait cycle per word), launching
// the stage evaluator, and early-rejecting on the first failed stage.
// Optional build macro CASCADE_STATS_EN adds saturating window/face counters
// (stat_windows, stat_faces) that advance on each result handshake.
module cascade_controller
    import cascade_controller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // Window request
    input  logic                         win_valid,
    output logic                         win_ready,
    input  logic [9:0]                   win_x,
    input  logic [9:0]                   win_y,
    input  logic [7:0]                   num_stages,
    input  logic [ADDR_WIDTH-1:0]        stage_table_base,
    // Stage-table read port
    output logic [ADDR_WIDTH-1:0]        tbl_addr,
    input  logic [DATA_WIDTH-1:0]        tbl_data,
    // Stage evaluator interface
    output logic                         se_start,
    output logic [ADDR_WIDTH-1:0]        se_base_addr,
    output logic signed [DATA_WIDTH-1:0] se_threshold,
    output logic [15:0]                  se_num_classifiers,
    input  logic                         se_done,
    input  logic                         se_passed,
    // Result
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         res_face,
    output logic [7:0]                   res_stages,
    output logic [9:0]                   res_x,
    output logic [9:0]                   res_y
`ifdef CASCADE_STATS_EN
    ,
    output logic [31:0]                  stat_windows,
    output logic [31:0]                  stat_faces
`endif
);

    state_e state_q, state_d;

    // Window context captured on accept
    logic [9:0]            x_q, y_q;
    logic [7:0]            num_stages_q;
    logic [ADDR_WIDTH-1:0] table_base_q;
    logic [7:0]            stage_idx_q;

    // Table fetch pointer
    logic [ADDR_WIDTH-1:0] tbl_addr_q;
    logic [1:0]            word_idx_q;

    // Parameters of the stage currently being evaluated
    logic [ADDR_WIDTH-1:0]        se_base_q;
    logic signed [DATA_WIDTH-1:0] se_thresh_q;
    logic [15:0]                  se_count_q;

    // Result fields
    logic       res_face_q;
    logic [7:0] res_stages_q;

    logic                  win_accept;
    logic                  res_accept;
    logic [7:0]            stage_idx_inc;
    logic                  last_stage;
    logic [ADDR_WIDTH-1:0] next_entry_addr;

    assign win_accept    = win_valid && (state_q == StIdle);
    assign res_accept    = res_ready && (state_q == StResult);
    assign stage_idx_inc = stage_idx_q + 8'd1;
    assign last_stage    = (stage_idx_inc == num_stages_q);
    // Truncation to ADDR_WIDTH gives the required modulo-2^ADDR_WIDTH wrap.
    assign next_entry_addr = table_base_q +
                             ADDR_WIDTH'(StageStride) * ADDR_WIDTH'(stage_idx_inc);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = (num_stages == 8'd0) ? StResult : StTblWait;
                end
            end
            StTblWait: state_d = StTblRead;
            StTblRead: state_d = (word_idx_q == WordCount) ? StSeStart : StTblWait;
            StSeStart: state_d = StSeWait;
            StSeWait: begin
                if (se_done) begin
                    if (!se_passed || last_stage) begin
                        state_d = StResult;
                    end else begin
                        state_d = StTblWait;
                    end
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        win_ready = (state_q == StIdle);
        se_start  = (state_q == StSeStart);
        res_valid = (state_q == StResult);
    end

    // Window context and stage index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            num_stages_q <= '0;
            table_base_q <= '0;
            stage_idx_q  <= '0;
        end else if (win_accept) begin
            x_q          <= win_x;
            y_q          <= win_y;
            num_stages_q <= num_stages;
            table_base_q <= stage_table_base;
            stage_idx_q  <= '0;
        end else if (state_q == StSeWait && se_done && se_passed) begin
            stage_idx_q  <= stage_idx_inc;
        end
    end

    // Table fetch pointer: word 0 of entry 0 on accept, then word-by-word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_addr_q <= '0;
            word_idx_q <= WordBase;
        end else if (win_accept) begin
            tbl_addr_q <= stage_table_base;
            word_idx_q <= WordBase;
        end else if (state_q == StTblRead && word_idx_q != WordCount) begin
            tbl_addr_q <= tbl_addr_q + 1'b1;
            word_idx_q <= word_idx_q + 2'd1;
        end else if (state_q == StSeWait && se_done && se_passed && !last_stage) begin
            tbl_addr_q <= next_entry_addr;
            word_idx_q <= WordBase;
        end
    end

    // Stage parameters, only written in TBL_READ so they hold through SE_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se_base_q   <= '0;
            se_thresh_q <= '0;
            se_count_q  <= '0;
        end else if (state_q == StTblRead) begin
            case (word_idx_q)
                WordBase:   se_base_q   <= tbl_data[ADDR_WIDTH-1:0];
                WordThresh: se_thresh_q <= $signed(tbl_data);
                default:    se_count_q  <= tbl_data[15:0];
            endcase
        end
    end

    // Result fields: set when entering RESULT, held until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_face_q   <= 1'b0;
            res_stages_q <= '0;
        end else if (win_accept && num_stages == 8'd0) begin
            res_face_q   <= 1'b1;
            res_stages_q <= '0;
        end else if (state_q == StSeWait && se_done) begin
            if (!se_passed) begin
                res_face_q   <= 1'b0;
                res_stages_q <= stage_idx_q;
            end else if (last_stage) begin
                res_face_q   <= 1'b1;
                res_stages_q <= stage_idx_inc;
            end
        end
    end

    assign tbl_addr           = tbl_addr_q;
    assign se_base_addr       = se_base_q;
    assign se_threshold       = se_thresh_q;
    assign se_num_classifiers = se_count_q;
    assign res_face           = res_face_q;
    assign res_stages         = res_stages_q;
    assign res_x              = x_q;
    assign res_y              = y_q;

`ifdef CASCADE_STATS_EN
    logic [31:0] stat_windows_q, stat_faces_q;

    // Saturating result counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_windows_q <= '0;
            stat_faces_q   <= '0;
        end else if (res_accept) begin
            if (stat_windows_q != '1) begin
                stat_windows_q <= stat_windows_q + 32'd1;
            end
            if (res_face_q && stat_faces_q != '1) begin
                stat_faces_q <= stat_faces_q + 32'd1;
            end
        end
    end

    assign stat_windows = stat_windows_q;
    assign stat_faces   = stat_faces_q;
`else
    // Handshake decode only feeds the counters.
    logic unused_res_accept;
    assign unused_res_accept = res_accept;
`endif

endmodule

// File: tb/tb_cascade_controller.sv
// Scoreboard bench for cascade_controller: a ROM model with one cycle of read
// latency, a stage-evaluator model, and monitors that pop expected stage
// parameters and results as the DUT presents them.
module tb_cascade_controller;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              win_valid = 1'b0;
    logic              win_ready;
    logic [9:0]        win_x = '0, win_y = '0;
    logic [7:0]        num_stages = '0;
    logic [AW-1:0]     stage_table_base = '0;
    logic [AW-1:0]     tbl_addr;
    logic [DW-1:0]     tbl_data = '0;
    logic              se_start;
    logic [AW-1:0]     se_base_addr;
    logic signed [DW-1:0] se_threshold;
    logic [15:0]       se_num_classifiers;
    logic              se_done = 1'b0, se_passed = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic              res_face;
    logic [7:0]        res_stages;
    logic [9:0]        res_x, res_y;
`ifdef CASCADE_STATS_EN
    logic [31:0]       stat_windows, stat_faces;
`endif
    logic [31:0]       se_thr_bits;
    assign se_thr_bits = se_threshold;

    always #5 clk = ~clk;

    cascade_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x), .win_y(win_y),
        .num_stages(num_stages), .stage_table_base(stage_table_base),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .se_start(se_start), .se_base_addr(se_base_addr), .se_threshold(se_threshold),
        .se_num_classifiers(se_num_classifiers), .se_done(se_done), .se_passed(se_passed),
        .res_valid(res_valid), .res_ready(res_ready), .res_face(res_face),
        .res_stages(res_stages), .res_x(res_x), .res_y(res_y)
`ifdef CASCADE_STATS_EN
        , .stat_windows(stat_windows), .stat_faces(stat_faces)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] base;
        logic [31:0]   thr;
        logic [15:0]   cnt;
    } se_exp_t;

    typedef struct packed {
        logic       face;
        logic [7:0] stages;
        logic [9:0] x;
        logic [9:0] y;
    } res_exp_t;

    se_exp_t  se_q[$];
    res_exp_t res_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM: data for the address presented one cycle earlier
    logic [31:0] rom [0:255];
    logic [7:0]  rom_prev = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tbl_data = rom[rom_prev];
            rom_prev = tbl_addr[7:0];
        end
    end

    // Stage evaluator model: done SE_LAT+1 cycles after start, fails at fail_at
    int se_lat = 2;
    int fail_at = -1;
    int stage_ptr = 0;
    bit spur_en = 1'b0;
    bit se_busy = 1'b0;
    int se_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            se_done = 1'b0;
            se_passed = 1'b0;
            if (!rst_n) begin
                se_busy = 1'b0;
            end else begin
                if (se_busy) begin
                    if (se_cnt == 0) begin
                        se_done = 1'b1;
                        se_passed = (stage_ptr != fail_at);
                        stage_ptr++;
                        se_busy = 1'b0;
                    end else begin
                        se_cnt--;
                    end
                end else if (spur_en && !se_start) begin
                    // stray completion outside SE_WAIT: must be ignored
                    se_done = 1'b1;
                    se_passed = 1'b0;
                end
                if (se_start) begin
                    se_busy = 1'b1;
                    se_cnt = se_lat;
                end
            end
        end
    end

    // Monitor: stage launches, parameter stability, results
    int pulse_cnt = 0;
    bit holding = 1'b0;
    se_exp_t hold_e;
    logic [AW-1:0] forbidden = '1;
    bit fhit = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (tbl_addr == forbidden) fhit = 1'b1;
            if (se_start) begin
                pulse_cnt++;
                chk("se_start_expected", 64'(se_q.size() != 0), 64'd1);
                if (se_q.size() != 0) begin
                    hold_e = se_q.pop_front();
                    chk("se_base_addr", 64'(se_base_addr), 64'(hold_e.base));
                    chk("se_threshold", 64'(se_thr_bits), 64'(hold_e.thr));
                    chk("se_num_classifiers", 64'(se_num_classifiers), 64'(hold_e.cnt));
                    holding = 1'b1;
                end
            end else if (holding) begin
                chk("se_base_stable", 64'(se_base_addr), 64'(hold_e.base));
                chk("se_thr_stable", 64'(se_thr_bits), 64'(hold_e.thr));
                chk("se_cnt_stable", 64'(se_num_classifiers), 64'(hold_e.cnt));
                if (se_done) holding = 1'b0;
            end
            if (res_valid && res_ready) begin
                chk("result_expected", 64'(res_q.size() != 0), 64'd1);
                if (res_q.size() != 0) begin
                    res_exp_t e;
                    e = res_q.pop_front();
                    chk("res_face", 64'(res_face), 64'(e.face));
                    chk("res_stages", 64'(res_stages), 64'(e.stages));
                    chk("res_x", 64'(res_x), 64'(e.x));
                    chk("res_y", 64'(res_y), 64'(e.y));
                end
            end
        end
    end

    int exp_win = 0;
    int exp_face = 0;

    // Expected parameters for table A entries (base 0x40), from the ROM fill
    task automatic push_table_a(input int n, input int fail);
        for (int k = 0; k < n; k++) begin
            se_q.push_back('{base: AW'(32'h100 + 32'h10 * k),
                             thr: 32'(-50 - k), cnt: 16'(9 + k)});
            if (k == fail) break;
        end
    endtask

    task automatic issue(input logic [9:0] x, input logic [9:0] y, input int n,
                         input logic [AW-1:0] base);
        for (int i = 0; i < 100; i++) begin
            if (win_ready) break;
            @(posedge clk);
            #1;
        end
        chk("win_ready_before_issue", 64'(win_ready), 64'd1);
        win_x = x;
        win_y = y;
        num_stages = 8'(n);
        stage_table_base = base;
        win_valid = 1'b1;
        @(posedge clk);
        #1;
        win_valid = 1'b0;
    endtask

    task automatic wait_results();
        for (int i = 0; i < 1000; i++) begin
            if (res_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("result_arrived", 64'(res_q.size()), 64'd0);
        res_q.delete();
    endtask

    // One complete window; caller has already pushed stage expectations
    task automatic run_window(input logic [9:0] x, input logic [9:0] y, input int n,
                              input logic [AW-1:0] base, input int fail);
        bit face;
        int pulses;
        face = (fail < 0) || (fail >= n);
        pulses = face ? n : fail + 1;
        fail_at = fail;
        stage_ptr = 0;
        pulse_cnt = 0;
        res_q.push_back('{face: face, stages: face ? 8'(n) : 8'(fail), x: x, y: y});
        exp_win++;
        if (face) exp_face++;
        issue(x, y, n, base);
        if (n == 0) chk("zero_stage_res_valid_next", 64'(res_valid), 64'd1);
        wait_results();
        chk("se_start_pulses", 64'(pulse_cnt), 64'(pulses));
        chk("se_queue_drained", 64'(se_q.size()), 64'd0);
        se_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_win_ready"}, 64'(win_ready), 64'd1);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_se_start"}, 64'(se_start), 64'd0);
        chk({tag, "_tbl_addr"}, 64'(tbl_addr), 64'd0);
        chk({tag, "_se_base"}, 64'(se_base_addr), 64'd0);
        chk({tag, "_se_thr"}, 64'(se_thr_bits), 64'd0);
        chk({tag, "_se_cnt"}, 64'(se_num_classifiers), 64'd0);
        chk({tag, "_res_fields"}, {27'd0, res_face, res_stages, res_x, res_y}, 64'd0);
`ifdef CASCADE_STATS_EN
        chk({tag, "_stats"}, {stat_windows, stat_faces}, 64'd0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            rom[64 + 4*k]     = 32'hFFF0_0000 | (32'h100 + 32'h10 * k);
            rom[64 + 4*k + 1] = 32'(-50 - k);
            rom[64 + 4*k + 2] = 32'hABCD_0000 | 32'(9 + k);
            rom[64 + 4*k + 3] = 32'hDEAD_BEEF;
        end
        // Entry straddling the top of the address space
        rom[8'hFC] = 32'h0003_ABCD;
        rom[8'hFD] = 32'd7;
        rom[8'hFE] = 32'h0000_0003;
        rom[8'hFF] = 32'hDEAD_BEEF;
        rom[8'h00] = 32'h0000_0020;
        rom[8'h01] = 32'hFFFF_FFFF;
        rom[8'h02] = 32'h0000_0001;
        rom[8'h03] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No stages: immediate face
        run_window(10'd5, 10'd6, 0, AW'(17'h40), -1);

        // Three stages, all pass
        push_table_a(3, -1);
        run_window(10'd100, 10'd200, 3, AW'(17'h40), -1);

        // Five stages, stage 2 rejects; entry 3 must never be addressed
        forbidden = AW'(17'h40 + 17'd12);
        fhit = 1'b0;
        push_table_a(5, 2);
        run_window(10'd1, 10'd1023, 5, AW'(17'h40), 2);
        chk("tbl_addr_below_entry3", 64'(fhit), 64'd0);
        forbidden = '1;

        // Reject on the very first stage
        push_table_a(2, 0);
        run_window(10'd7, 10'd8, 2, AW'(17'h40), 0);

        // Stray se_done outside SE_WAIT is ignored
        spur_en = 1'b1;
        push_table_a(2, -1);
        run_window(10'd9, 10'd10, 2, AW'(17'h40), -1);
        spur_en = 1'b0;

        // Result back-pressure for 10 cycles
        res_ready = 1'b0;
        fail_at = -1;
        stage_ptr = 0;
        pulse_cnt = 0;
        push_table_a(1, -1);
        res_q.push_back('{face: 1'b1, stages: 8'd1, x: 10'd300, y: 10'd301});
        exp_win++;
        exp_face++;
        issue(10'd300, 10'd301, 1, AW'(17'h40));
        for (int i = 0; i < 200; i++) begin
            if (res_valid) break;
            @(posedge clk);
            #1;
        end
        chk("bp_res_valid_seen", 64'(res_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {res_valid, win_ready, res_face, res_stages, res_x, res_y},
                {1'b1, 1'b0, 1'b1, 8'd1, 10'd300, 10'd301});
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {res_valid, win_ready}, 64'b01);
        chk("bp_result_popped", 64'(res_q.size()), 64'd0);
        chk("bp_pulses", 64'(pulse_cnt), 64'd1);

        // Table entries wrapping past the top of the address space
        se_q.push_back('{base: AW'(17'h1ABCD), thr: 32'd7, cnt: 16'd3});
        se_q.push_back('{base: AW'(17'h00020), thr: 32'hFFFF_FFFF, cnt: 16'd1});
        run_window(10'd11, 10'd12, 2, AW'(17'h1FFFC), -1);

        // Reset while the evaluator is busy: window is dropped
        fail_at = -1;
        stage_ptr = 0;
        push_table_a(3, -1);
        issue(10'd50, 10'd60, 3, AW'(17'h40));
        for (int i = 0; i < 100; i++) begin
            if (se_start) break;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_se_start_seen", 64'(se_start), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        se_q.delete();
        exp_win = 0;
        exp_face = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_no_result", {res_valid, win_ready}, 64'b01);
            @(posedge clk);
            #1;
        end

        // Four windows, one face
        push_table_a(3, -1);
        run_window(10'd20, 10'd21, 3, AW'(17'h40), -1);
        push_table_a(2, 0);
        run_window(10'd22, 10'd23, 2, AW'(17'h40), 0);
        push_table_a(4, 1);
        run_window(10'd24, 10'd25, 4, AW'(17'h40), 1);
        push_table_a(1, 0);
        run_window(10'd26, 10'd27, 1, AW'(17'h40), 0);

`ifdef CASCADE_STATS_EN
        chk("stat_windows", 64'(stat_windows), 64'(exp_win));
        chk("stat_faces", 64'(stat_faces), 64'(exp_face));
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cascade_controller.md
CASCADE_CONTROLLER -- requirements
Module: cascade_controller

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, table word and threshold width; ADDR_WIDTH, default 17, cascade ROM address width.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 win_valid  in  1; win_ready  out  1: window request handshake, accepted when both are high.
REQ-005 win_x, win_y  in  10 each: window origin, captured on accept.
REQ-006 num_stages  in  8; stage_table_base  in  ADDR_WIDTH: both captured on accept.
REQ-007 tbl_addr  out  ADDR_WIDTH; tbl_data  in  DATA_WIDTH: stage-table read port into the cascade ROM.
REQ-008 se_start  out  1: one-cycle start pulse to the stage evaluator.
REQ-009 se_base_addr  out  ADDR_WIDTH: stage classifier base address.
REQ-010 se_threshold  out  DATA_WIDTH signed: stage threshold.
REQ-011 se_num_classifiers  out  16: weak classifier count for the stage.
REQ-012 se_done  in  1; se_passed  in  1: stage completion and result.
REQ-013 res_valid  out  1; res_ready  in  1: result handshake.
REQ-014 res_face  out  1; res_stages  out  8; res_x, res_y  out  10: result fields.

Function
REQ-015 The FSM SHALL have states IDLE, TBL_WAIT, TBL_READ, SE_START, SE_WAIT, RESULT.
REQ-016 win_ready SHALL be 1 only in IDLE; on accept: stage_idx=0, go to TBL_WAIT, or to RESULT with res_face=1, res_stages=0 when num_stages==0.
REQ-017 Each stage table entry SHALL be 4 words at stage_table_base+4*stage_idx: word0[ADDR_WIDTH-1:0]=classifier base, word1=signed threshold, word2[15:0]=classifier count, word3 reserved and never read.
REQ-018 ROM latency SHALL be one wait cycle: tbl_addr is set, TBL_WAIT elapses, then TBL_READ samples tbl_data.
REQ-019 TBL_READ SHALL latch word k (k=0..2); after word2 it goes to SE_START, otherwise it sets tbl_addr+1 and returns to TBL_WAIT.
REQ-020 SE_START SHALL assert se_start for exactly one cycle with se_base_addr, se_threshold and se_num_classifiers stable from then until se_done, then enter SE_WAIT.
REQ-021 SE_WAIT on se_done&&se_passed SHALL increment stage_idx; at num_stages go to RESULT with res_face=1, otherwise go to TBL_WAIT for the next entry.
REQ-022 SE_WAIT on se_done&&!se_passed SHALL early-reject: res_face=0, res_stages=stage_idx (stages passed), go to RESULT.
REQ-023 se_done outside SE_WAIT SHALL be ignored.
REQ-024 RESULT SHALL hold res_valid=1 and all res_* stable until res_ready, then return to IDLE; a new window is accepted no earlier than the following cycle.
REQ-025 Stage address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; stage_idx is 8-bit and cannot exceed 255.

Reset
REQ-026 Reset SHALL force state=IDLE and drive all outputs to 0 except win_ready=1; res_*, se_*, tbl_addr and internal registers clear.
REQ-027 Reset mid-window SHALL abandon the window with no result; the stage evaluator is reset on the same rst_n.

Configuration
REQ-028 With CASCADE_STATS_EN defined, outputs stat_windows[31:0] and stat_faces[31:0] SHALL exist, incrementing (saturating) on each result handshake and on each handshake with res_face=1; both reset to 0.
REQ-029 Without CASCADE_STATS_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings, the stage entry stride (4) and the word offsets (0/1/2).
REQ-031 The block SHALL have no sub-module; the stage_evaluator is instantiated alongside it at the top level.

Verification
REQ-032 num_stages=0 -> res_valid the cycle after accept, res_face=1, res_stages=0, no se_start.
REQ-033 3 stages, all pass, entry0={0x100,-50,9} -> se_base_addr=0x100, se_threshold=-50, se_num_classifiers=9; 3 se_start pulses; res_face=1, res_stages=3.
REQ-034 5 stages, stage 2 fails -> exactly 3 se_start pulses, res_face=0, res_stages=2; tbl_addr never reaches base+12.
REQ-035 res_ready held low 10 cycles -> res_* stable, win_ready=0 throughout; release -> IDLE next cycle.
REQ-036 rst_n low during SE_WAIT -> all outputs 0, win_ready=1, no res_valid; a subsequent window completes normally.
REQ-037 CASCADE_STATS_EN build, 4 windows with 1 face -> stat_windows=4, stat_faces=1.
